// File: rtl/coin_return_dispenser_pkg.sv
// coin_return_dispenser_pkg: shared coin indices, unit values and FSM states
package coin_return_dispenser_pkg;

    localparam int NUM_COINS = 3;
    localparam int COIN_100  = 0;
    localparam int COIN_500  = 1;
    localparam int COIN_1000 = 2;

    localparam logic [3:0] VAL_100  = 4'd1;
    localparam logic [3:0] VAL_500  = 4'd5;
    localparam logic [3:0] VAL_1000 = 4'd10;

    typedef enum logic [1:0] {IDLE, EJECT, GAP, FAULT} state_t;

    function automatic logic [3:0] coin_value(input logic [1:0] k);
        return k == 2'(COIN_1000) ? VAL_1000 : k == 2'(COIN_500) ? VAL_500 : VAL_100;
    endfunction

endpackage

// File: rtl/coin_return_dispenser_counter.sv
// coin_sat_counter: up/down counter that saturates high and flags dropped increments
module coin_sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             overflow
);

    // simultaneous inc and dec cancel; overflow stays set until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (inc && !dec) begin
            if (&cnt) overflow <= 1'b1;
            else      cnt      <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/coin_return_dispenser.sv
// coin_return_dispenser: buffers returned coins and feeds the hopper largest-first
module coin_return_dispenser
    import coin_return_dispenser_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int TIMEOUT    = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       i_return_coin,
    input  logic             i_eject_done,
    input  logic             i_fault_clear,
    output logic [2:0]       o_eject,
    output logic             o_busy,
    output logic             o_fault,
    output logic [2:0]       o_overflow,
    output logic [CNT_W+3:0] o_pending_value,
    output logic [15:0]      o_paid_value
);

    localparam int PW = CNT_W + 4;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t           state;
    logic [1:0]       sel;
    logic [1:0]       hi;
    logic             any;
    logic [TW-1:0]    timer;
    logic [GW-1:0]    gap_cnt;
    logic [2:0]       dec;
    logic [CNT_W-1:0] cnt [NUM_COINS];

    for (genvar k = 0; k < NUM_COINS; k++) begin : g_cnt
        coin_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .inc      (i_return_coin[k]),
            .dec      (dec[k]),
            .cnt      (cnt[k]),
            .overflow (o_overflow[k])
        );
    end

    // a completed eject retires one coin of the selected denomination
    always_comb begin
        dec = '0;
        for (int k = 0; k < NUM_COINS; k++)
            dec[k] = state == EJECT && i_eject_done && sel == 2'(k);
    end

    // highest nonzero denomination wins, and front-panel values
    always_comb begin
        any             = cnt[COIN_1000] != '0 || cnt[COIN_500] != '0 || cnt[COIN_100] != '0;
        hi              = cnt[COIN_1000] != '0 ? 2'(COIN_1000) : cnt[COIN_500] != '0 ? 2'(COIN_500) : 2'(COIN_100);
        o_busy          = state != IDLE || any;
        o_pending_value = PW'(cnt[COIN_1000]) * PW'(VAL_1000)
                        + PW'(cnt[COIN_500])  * PW'(VAL_500)
                        + PW'(cnt[COIN_100]);
    end

    // hopper sequencing: select, hold request, enforce gap, trap stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sel          <= '0;
            o_eject      <= '0;
            o_fault      <= 1'b0;
            o_paid_value <= '0;
            timer        <= '0;
            gap_cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    sel     <= hi;
                    o_eject <= 3'b001 << hi;
                    timer   <= '0;
                    state   <= EJECT;
                end
                EJECT: if (i_eject_done) begin
                    o_paid_value <= o_paid_value + 16'(coin_value(sel));
                    o_eject      <= '0;
                    gap_cnt      <= '0;
                    state        <= GAP;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    o_eject <= '0;
                    o_fault <= 1'b1;
                    state   <= FAULT;
                end else begin
                    timer <= timer + 1'b1;
                end
                GAP: if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
                     else gap_cnt <= gap_cnt + 1'b1;
                FAULT: if (i_fault_clear) begin
                    o_fault <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_return_dispenser.sv
// tb_coin_return_dispenser: table vectors plus eject-order scoreboard for the coin dispenser
module tb_coin_return_dispenser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  i_return_coin = '0;
    logic        i_eject_done;
    logic        i_fault_clear = 1'b0;
    logic [2:0]  o_eject;
    logic        o_busy;
    logic        o_fault;
    logic [2:0]  o_overflow;
    logic [7:0]  o_pending_value;
    logic [15:0] o_paid_value;

    logic hop_done = 1'b0;
    logic extra_done = 1'b0;
    int   ack_delay = -1;
    int   checks = 0;
    int   errors = 0;
    logic [2:0] sb[$];

    assign i_eject_done = hop_done | extra_done;

    coin_return_dispenser dut (
        .clk             (clk),
        .reset           (reset),
        .i_return_coin   (i_return_coin),
        .i_eject_done    (i_eject_done),
        .i_fault_clear   (i_fault_clear),
        .o_eject         (o_eject),
        .o_busy          (o_busy),
        .o_fault         (o_fault),
        .o_overflow      (o_overflow),
        .o_pending_value (o_pending_value),
        .o_paid_value    (o_paid_value)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        tick(1);
        while (o_busy && n < 300) begin
            tick(1);
            n++;
        end
        check({name, "_idle_timeout"}, int'(n < 300), 1);
    endtask

    // hopper model: acks after the request has been visible for ack_delay cycles
    initial begin
        int seen = 0;
        forever begin
            @(posedge clk);
            #1;
            hop_done = 1'b0;
            if (o_eject == '0) seen = 0;
            else begin
                seen++;
                if (ack_delay > 0 && seen == ack_delay) hop_done = 1'b1;
            end
        end
    end

    // scoreboard: every new eject request must match the next expected coin
    initial begin
        logic [2:0] prev = '0;
        logic [2:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (o_eject != '0 && prev == '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL eject_order: got %b expected none", o_eject);
                end else begin
                    exp = sb.pop_front();
                    if (o_eject != exp) begin
                        errors++;
                        $display("FAIL eject_order: got %b expected %b", o_eject, exp);
                    end
                end
            end
            prev = o_eject;
        end
    end

    typedef struct {
        logic [2:0] coin;
        int         pend;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n;
        tbl[0] = '{3'b001, 1};
        tbl[1] = '{3'b010, 5};
        tbl[2] = '{3'b100, 10};
        tbl[3] = '{3'b011, 6};
        tbl[4] = '{3'b101, 11};
        tbl[5] = '{3'b110, 15};
        tbl[6] = '{3'b111, 16};

        // reset state and single 100 coin with a slow hopper
        do_reset();
        check("rst_eject", o_eject, 0);
        check("rst_fault", o_fault, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_pend", o_pending_value, 0);
        check("rst_paid", o_paid_value, 0);
        check("rst_busy", o_busy, 0);
        ack_delay = 3;
        sb.push_back(3'b001);
        i_return_coin = 3'b001;
        tick(1);
        i_return_coin = '0;
        check("t1_pend1", o_pending_value, 1);
        check("t1_eject_pre", o_eject, 0);
        tick(1);
        check("t1_eject", o_eject, 3'b001);
        tick(2);
        check("t1_eject_held", o_eject, 3'b001);
        tick(1);
        check("t1_eject_off", o_eject, 0);
        check("t1_pend0", o_pending_value, 0);
        check("t1_paid", o_paid_value, 1);
        tick(1);
        check("t1_busy_gap", o_busy, 1);
        tick(1);
        check("t1_busy_done", o_busy, 0);

        // table: every pulse pattern drains largest first with prompt acks
        ack_delay = 1;
        for (int i = 0; i < 7; i++) begin
            do_reset();
            for (int k = 2; k >= 0; k--)
                if (tbl[i].coin[k]) sb.push_back(3'b001 << k);
            i_return_coin = tbl[i].coin;
            tick(1);
            i_return_coin = '0;
            check($sformatf("tbl%0d_pend", i), o_pending_value, tbl[i].pend);
            wait_idle($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_paid", i), o_paid_value, tbl[i].pend);
            check($sformatf("tbl%0d_pend0", i), o_pending_value, 0);
        end

        // 111 then 010: 1000, 500, 500, 100
        do_reset();
        sb.push_back(3'b100);
        sb.push_back(3'b010);
        sb.push_back(3'b010);
        sb.push_back(3'b001);
        i_return_coin = 3'b111;
        tick(1);
        i_return_coin = 3'b010;
        tick(1);
        i_return_coin = '0;
        check("t2_pend21", o_pending_value, 21);
        tick(1);
        check("t2_pend11", o_pending_value, 11);
        tick(4);
        check("t2_pend6", o_pending_value, 6);
        tick(4);
        check("t2_pend1", o_pending_value, 1);
        tick(4);
        check("t2_pend0", o_pending_value, 0);
        wait_idle("t2");
        check("t2_paid", o_paid_value, 21);

        // stalled hopper times out after exactly 16 request cycles
        do_reset();
        ack_delay = -1;
        sb.push_back(3'b010);
        i_return_coin = 3'b010;
        tick(1);
        i_return_coin = '0;
        tick(1);
        n = 0;
        while (o_eject == 3'b010 && n < 40) begin
            n++;
            tick(1);
        end
        check("t3_eject_cycles", n, 16);
        check("t3_eject_off", o_eject, 0);
        check("t3_fault", o_fault, 1);
        check("t3_pend", o_pending_value, 5);
        extra_done = 1'b1;
        tick(1);
        extra_done = 1'b0;
        tick(2);
        check("t3_done_ignored", o_eject, 0);
        check("t3_fault_held", o_fault, 1);
        ack_delay = 1;
        sb.push_back(3'b010);
        i_fault_clear = 1'b1;
        tick(1);
        i_fault_clear = 1'b0;
        check("t3_fault_clr", o_fault, 0);
        wait_idle("t3");
        check("t3_paid", o_paid_value, 5);
        check("t3_pend0", o_pending_value, 0);

        // saturation of the 100 counter with the hopper held off
        do_reset();
        ack_delay = -1;
        sb.push_back(3'b001);
        i_return_coin = 3'b001;
        tick(15);
        check("t4_ovf_pre", o_overflow, 0);
        check("t4_pend15a", o_pending_value, 15);
        tick(2);
        i_return_coin = '0;
        check("t4_ovf", o_overflow, 3'b001);
        check("t4_pend15", o_pending_value, 15);

        // a 1000 coin arriving during the gap preempts pending 100 coins
        do_reset();
        check("t5_ovf_clr", o_overflow, 0);
        ack_delay = 1;
        sb.push_back(3'b001);
        sb.push_back(3'b100);
        sb.push_back(3'b001);
        sb.push_back(3'b001);
        i_return_coin = 3'b001;
        tick(3);
        check("t5_pend_gap", o_pending_value, 2);
        check("t5_paid_gap", o_paid_value, 1);
        i_return_coin = 3'b100;
        tick(1);
        i_return_coin = '0;
        check("t5_pend12", o_pending_value, 12);
        wait_idle("t5");
        check("t5_paid", o_paid_value, 13);

        // asynchronous reset in the middle of a 500 eject
        ack_delay = -1;
        sb.push_back(3'b010);
        i_return_coin = 3'b010;
        tick(3);
        i_return_coin = '0;
        tick(2);
        check("t6_eject_pre", o_eject, 3'b010);
        check("t6_pend_pre", o_pending_value, 15);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_eject", o_eject, 0);
        check("t6_async_pend", o_pending_value, 0);
        check("t6_async_paid", o_paid_value, 0);
        check("t6_async_busy", o_busy, 0);
        tick(1);
        reset = 1'b0;
        extra_done = 1'b1;
        tick(1);
        extra_done = 1'b0;
        tick(5);
        check("t6_post_eject", o_eject, 0);
        check("t6_post_paid", o_paid_value, 0);
        check("t6_post_busy", o_busy, 0);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_return_dispenser.md
Name: coin_return_dispenser

Overview:
- Downstream of the vending machine. Consumes its one-cycle o_return_coin pulses (bit0=100, bit1=500, bit2=1000), which may be simultaneous.
- Buffers pending coins per denomination and drives the physical change hopper one coin at a time, largest denomination first, over a request/done handshake.
- Detects hopper stalls and reports pending and dispensed value for the front panel.

Parameters:
- CNT_W, 4, width of each per-denomination pending counter; saturates at 2^CNT_W-1.
- TIMEOUT, 16, cycles allowed in EJECT without i_eject_done before entering FAULT.
- GAP_CYCLES, 2, mandatory idle cycles between consecutive ejects; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- i_return_coin  input  3  one-cycle coin-return pulses from the vending machine, any combination
- i_eject_done  input  1  hopper pulse: requested coin physically ejected
- i_fault_clear  input  1  operator pulse: leave FAULT and retry
- o_eject  output  3  one-hot hopper request, held until done or timeout
- o_busy  output  1  state != IDLE or any pending count nonzero
- o_fault  output  1  high while in FAULT
- o_overflow  output  3  sticky per denomination: a pulse arrived while that counter was saturated
- o_pending_value  output  CNT_W+4  pending value in units of 100 = 10*cnt2 + 5*cnt1 + cnt0
- o_paid_value  output  16  cumulative dispensed value in units of 100; wraps modulo 2^16

Behaviour:
- Reset (async, any cycle, including mid-eject):
  - Counters, o_eject, o_fault, o_overflow, o_paid_value and the timer all go to 0; state goes to IDLE.
  - No output glitches after release.
- Counting:
  - Each edge, cnt[k] increments when i_return_coin[k]=1 and decrements when the current eject of denomination k completes.
  - Increment and decrement in the same cycle leave cnt[k] unchanged.
  - Increment at saturation is dropped and o_overflow[k] is set. o_overflow is cleared only by reset.
  - Counting continues in every state, including FAULT.
- FSM: IDLE, EJECT, GAP, FAULT.
  - IDLE: if any cnt > 0, select the highest k with cnt[k] > 0 (priority 2 > 1 > 0), latch sel, go to EJECT with o_eject = onehot(sel) registered and timer = 0.
  - Latency: a pulse sampled at edge t produces o_eject high after edge t+1.
  - EJECT: o_eject held stable and the timer increments each cycle.
    - i_eject_done=1 → cnt[sel] - 1, o_paid_value += value(sel) (1/5/10), o_eject = 0, go to GAP.
    - Otherwise, when timer reaches TIMEOUT-1 → o_eject = 0, o_fault = 1, go to FAULT; cnt is not decremented.
    - i_eject_done and timeout in the same cycle → done wins.
  - GAP: o_eject = 0 for exactly GAP_CYCLES cycles, then IDLE. Priority re-evaluates in IDLE, so a newly arrived larger coin preempts.
  - FAULT: o_eject = 0. i_fault_clear → IDLE with o_fault = 0 on the next edge; pending counts are preserved and retried.
  - i_eject_done outside EJECT is ignored; i_fault_clear outside FAULT is ignored.
- o_pending_value and o_busy are combinational from registered state. Ejecting all counters, each saturated at 15, pays 240 units.

Decomposition:
- Shared package:
  - Coin index constants (COIN_100=0, COIN_500=1, COIN_1000=2).
  - Coin unit values (1, 5, 10).
  - State enum {IDLE, EJECT, GAP, FAULT}.
  - NUM_COINS=3.
- Sub-module: coin_sat_counter (CNT_W-bit up/down saturating counter with overflow flag), instantiated three times. The FSM, priority select, timer and value arithmetic live in the top module.

Test Plan:
- Reset, then one i_return_coin=3'b001 pulse; hopper returns done 3 cycles after o_eject rises.
  - o_eject=001 appears one cycle after the pulse is registered; o_pending_value goes 1→0; o_paid_value=1.
  - After GAP_CYCLES, o_busy=0.
- Simultaneous pulse 3'b111, then 3'b010; hopper acks each eject after 1 cycle.
  - Eject order is 100 (1000), 010, 010, 001.
  - o_pending_value: 21→11→6→1→0; o_paid_value=21.
- Hopper never acks after a single 500 pulse.
  - o_eject=010 for exactly 16 cycles, then o_eject=0 and o_fault=1; o_pending_value stays 5.
  - Pulse i_fault_clear with a prompt ack → o_paid_value=5, o_fault=0.
- 17 consecutive 100 pulses with the hopper held off (no ack): cnt0 saturates at 15, o_overflow=001, o_pending_value=15.
- During the GAP after a 100 eject, with cnt0=2, inject a 1000 pulse: the next o_eject is 100, preempting the two 100 coins.
- Assert reset mid-EJECT with o_eject=010 and cnt1=3: all outputs go to 0 immediately (async).
  - After release, no eject occurs and i_eject_done is ignored.
